controle_cronometro: RTL and testbench
======================================

# controle_cronometro

Control unit for the tenth-of-second stopwatch counter (0–9999, wraps at 10000). It debounces two active-high push buttons, Iniciar and Zerar, and runs a four-state Moore FSM. The FSM drives the counter's `contaTempo` (count enable) and `zeraTempo` (clear) inputs. It also supplies the display path with either the live count or a frozen lap value. It sits between the board buttons and the counter/display-decoder pair.

## Interface

- `DEBOUNCE`, default 500000: consecutive clock cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz).
- `clk`  input  1: system clock; all state updates on rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `btnIniciar`  input  1: raw start/stop button, asynchronous, pressed = 1.
- `btnZerar`  input  1: raw lap/clear button, asynchronous, pressed = 1.
- `number`  input  14: live count from the counter, 0–9999.
- `contaTempo`  output  1: count enable to the counter.
- `zeraTempo`  output  1: clear to the counter.
- `display`  output  14: value for the display decoder.
- `estado`  output  2: current state, encoded ZERADO=0, CONTANDO=1, PARADO=2, VOLTA=3.

## Operation

**Input conditioning (per button, identical)**
- Two-flop synchronizer.
- Stability counter, width ceil(log2(DEBOUNCE+1)):
  - Cleared whenever the synchronized level differs from the debounced level.
  - Otherwise increments.
  - When it reaches DEBOUNCE, the debounced level takes the synchronized level and the counter clears.
- Press event: single-cycle pulse on a debounced 0→1 transition. Releases generate no event.
- Holding a button produces exactly one event.
- Glitches shorter than DEBOUNCE cycles produce no event.

**FSM (Moore; `evI`/`evZ` are the press events)**

| State | contaTempo | zeraTempo | display |
|---|---|---|---|
| ZERADO | 0 | 1 | 0 |
| CONTANDO | 1 | 0 | `number` |
| PARADO | 0 | 0 | `number` |
| VOLTA | 1 | 0 | `lap` |

- ZERADO: `zeraTempo` is held high, so the counter is held clear.
  - `evI` → CONTANDO.
  - `evZ` ignored.
- CONTANDO:
  - `evI` → PARADO.
  - `evZ` → VOLTA; `lap` register loads `number` on the same edge.
- VOLTA: counter keeps running while the display stays frozen.
  - `evZ` → CONTANDO.
  - `evI` → PARADO; display returns to the live value, which is frozen because counting has stopped.
- PARADO:
  - `evI` → CONTANDO (resume without clearing).
  - `evZ` → ZERADO.
- Simultaneous `evI` and `evZ` in one cycle: `evI` wins and `evZ` is discarded.
- Counter wrap 9999→0 needs no special handling. The FSM state is unaffected, and a lap latched before the wrap is held unchanged.
- `lap` is 14 bits, written only on the CONTANDO→VOLTA transition.

## Timing

**Reset**
- While `rst` is high: state = ZERADO, `contaTempo`=0, `zeraTempo`=1, `display`=0, `estado`=0.
- Also cleared: `lap`=0, synchronizers=0, debounced levels=0, stability counters=0.
- `rst` asserted mid-operation (any state, including mid-debounce) takes effect immediately, without waiting for `clk`.
- A button held through reset release produces an event once its debounced level rises, i.e. DEBOUNCE+3 edges after release.

**Latency**
- Raw button sampled high at edge 0 and held stable → state and outputs change at edge DEBOUNCE+3:
  - 2 edges for the synchronizer.
  - DEBOUNCE edges for the stability counter.
  - 1 edge for the state register.
- Outputs are pure decodes of the state register, so they change on the same edge as the state. Exception: `display` follows `number` combinationally in CONTANDO and PARADO.
- Lap capture: `lap` equals `number` as sampled at the transition edge.

**Counter interaction**
- One `zeraTempo` level lasting at least one clock fully clears the counter.
- Leaving ZERADO deasserts `zeraTempo` and asserts `contaTempo` on the same edge.

## Test plan

Bench uses DEBOUNCE=4 and a behavioral counter model.

1. Reset then idle:
   - `rst` pulse → `estado`=0, `zeraTempo`=1, `contaTempo`=0, `display`=0.
   - No change over 100 cycles.
2. Start with latency check:
   - `btnIniciar` high from edge 0 → `estado`=1 and `contaTempo`=1 exactly at edge 7, not edge 6.
   - Holding the button 50 cycles causes no further transition.
3. Bounce rejection:
   - `btnIniciar` toggled every 2 cycles for 20 cycles, then released → `estado` stays 0.
   - Pulse of 3 stable cycles → no event.
4. Lap:
   - In CONTANDO with `number`=123, press Zerar → `estado`=3 and `display`=123 while `number` advances to 200.
   - Press Zerar again → `estado`=1 and `display` tracks `number`.
5. Stop / resume / clear:
   - CONTANDO, press Iniciar → `estado`=2, `contaTempo`=0, `number` held at 456.
   - Press Iniciar → counting resumes from 456.
   - Press Iniciar again, then Zerar → `estado`=0, `zeraTempo`=1, `display`=0.
6. Simultaneous events and async reset:
   - Both buttons raised on the same edge in CONTANDO → `estado`=2 and `lap` unchanged.
   - `rst` asserted between clock edges in VOLTA → outputs at reset values before the next `clk` edge.

Source files
------------

// File: rtl/controle_cronometro.sv
// Stopwatch control: debounces Iniciar/Zerar, runs the ZERADO/CONTANDO/PARADO/VOLTA FSM,
// drives the counter enable/clear and selects live count or frozen lap for the display.
module controle_cronometro #(
  parameter int DEBOUNCE = 500000,
  localparam int CW = $clog2(DEBOUNCE + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnIniciar,
  input  logic        btnZerar,
  input  logic [13:0] number,
  output logic        contaTempo,
  output logic        zeraTempo,
  output logic [13:0] display,
  output logic [1:0]  estado
);

  typedef enum logic [1:0] {
    ZERADO   = 2'd0,
    CONTANDO = 2'd1,
    PARADO   = 2'd2,
    VOLTA    = 2'd3
  } state_t;

  // Bit 0 is Iniciar, bit 1 is Zerar.
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    ev;
  state_t        state_q, state_d;
  logic [13:0]   lap_q, lap_d;

  always_comb begin
    sync1_d    = {btnZerar, btnIniciar};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      // A pending level change must survive DEBOUNCE consecutive cycles to be accepted.
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE)) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign ev = deb_q & ~deb_prev_q;

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    unique case (state_q)
      ZERADO: begin
        if (ev[0]) state_d = CONTANDO;
      end
      CONTANDO: begin
        if (ev[0]) begin
          state_d = PARADO;
        end else if (ev[1]) begin
          state_d = VOLTA;
          lap_d   = number;
        end
      end
      PARADO: begin
        if (ev[0])      state_d = CONTANDO;
        else if (ev[1]) state_d = ZERADO;
      end
      VOLTA: begin
        if (ev[0])      state_d = PARADO;
        else if (ev[1]) state_d = CONTANDO;
      end
      default: state_d = ZERADO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      state_q    <= ZERADO;
      lap_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      state_q    <= state_d;
      lap_q      <= lap_d;
    end
  end

  // Moore decode; display follows number combinationally when not frozen.
  always_comb begin
    contaTempo = 1'b0;
    zeraTempo  = 1'b0;
    display    = '0;
    unique case (state_q)
      ZERADO:   zeraTempo = 1'b1;
      CONTANDO: begin
        contaTempo = 1'b1;
        display    = number;
      end
      PARADO:   display = number;
      VOLTA: begin
        contaTempo = 1'b1;
        display    = lap_q;
      end
      default: zeraTempo = 1'b1;
    endcase
  end

  assign estado = state_q;

endmodule

// File: tb/tb_controle_cronometro.sv
// Directed bench for controle_cronometro with DEBOUNCE=4 and a loadable counter model.
module tb_controle_cronometro;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btnIniciar = 1'b0;
  logic        btnZerar = 1'b0;
  logic [13:0] number;
  logic        contaTempo;
  logic        zeraTempo;
  logic [13:0] display;
  logic [1:0]  estado;

  int n_cmp = 0;
  int n_err = 0;

  logic        hold_m = 1'b0;
  logic        load_m = 1'b0;
  logic [13:0] load_val = '0;
  logic [13:0] cnt_m = '0;

  always #5 clk = ~clk;

  controle_cronometro #(.DEBOUNCE(4)) dut (
    .clk(clk), .rst(rst), .btnIniciar(btnIniciar), .btnZerar(btnZerar),
    .number(number), .contaTempo(contaTempo), .zeraTempo(zeraTempo),
    .display(display), .estado(estado)
  );

  // Behavioral counter 0..9999 with bench-side load/hold for directed values.
  always @(posedge clk) begin
    if (load_m)          cnt_m <= load_val;
    else if (hold_m)     cnt_m <= cnt_m;
    else if (zeraTempo)  cnt_m <= '0;
    else if (contaTempo) cnt_m <= (cnt_m == 14'd9999) ? 14'd0 : cnt_m + 14'd1;
  end
  assign number = cnt_m;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [13:0] v);
    load_val = v;
    load_m   = 1'b1;
    tick(1);
    load_m   = 1'b0;
  endtask

  // sel bit0 = Iniciar, bit1 = Zerar; event lands at edge 7, task returns after edge 19.
  task automatic press(input logic [1:0] sel);
    btnIniciar = sel[0];
    btnZerar   = sel[1];
    tick(10);
    btnIniciar = 1'b0;
    btnZerar   = 1'b0;
    tick(10);
  endtask

  initial begin
    // 1. reset and idle
    tick(3);
    chk("rst_estado", 16'(estado), 16'd0);
    chk("rst_zera", 16'(zeraTempo), 16'd1);
    rst = 1'b0;
    tick(1);
    chk("idle_conta", 16'(contaTempo), 16'd0);
    chk("idle_display", 16'(display), 16'd0);
    tick(100);
    chk("idle100_estado", 16'(estado), 16'd0);
    chk("idle100_zera", 16'(zeraTempo), 16'd1);

    // 3. bounce rejection (done from ZERADO)
    for (int i = 0; i < 10; i++) begin
      btnIniciar = ~btnIniciar;
      tick(2);
    end
    btnIniciar = 1'b0;
    tick(12);
    chk("bounce_estado", 16'(estado), 16'd0);
    btnIniciar = 1'b1;
    tick(3);
    btnIniciar = 1'b0;
    tick(12);
    chk("short_pulse_estado", 16'(estado), 16'd0);

    // 2. start latency: raw high sampled at edge 0, state moves at edge 7
    btnIniciar = 1'b1;
    tick(7);
    chk("lat_edge6_estado", 16'(estado), 16'd0);
    chk("lat_edge6_conta", 16'(contaTempo), 16'd0);
    tick(1);
    chk("lat_edge7_estado", 16'(estado), 16'd1);
    chk("lat_edge7_conta", 16'(contaTempo), 16'd1);
    chk("lat_edge7_zera", 16'(zeraTempo), 16'd0);
    tick(50);
    chk("hold_estado", 16'(estado), 16'd1);
    btnIniciar = 1'b0;
    tick(12);
    chk("release_estado", 16'(estado), 16'd1);
    chk("live_display", 16'(display), 16'(cnt_m));

    // 4. lap
    hold_m = 1'b1;
    load(14'd123);
    press(2'b10);
    chk("lap_estado", 16'(estado), 16'd3);
    chk("lap_display", 16'(display), 16'd123);
    load(14'd200);
    chk("lap_frozen", 16'(display), 16'd123);
    chk("lap_conta", 16'(contaTempo), 16'd1);
    press(2'b10);
    chk("unlap_estado", 16'(estado), 16'd1);
    chk("unlap_display", 16'(display), 16'd200);

    // 5. stop / resume / clear
    load(14'd456);
    press(2'b01);
    hold_m = 1'b0;
    tick(10);
    chk("stop_estado", 16'(estado), 16'd2);
    chk("stop_conta", 16'(contaTempo), 16'd0);
    chk("stop_number", 16'(number), 16'd456);
    chk("stop_display", 16'(display), 16'd456);
    press(2'b01);
    chk("resume_estado", 16'(estado), 16'd1);
    chk("resume_number", 16'(number), 16'd468);
    chk("resume_display", 16'(display), 16'd468);
    press(2'b01);
    chk("stop2_estado", 16'(estado), 16'd2);
    press(2'b10);
    chk("clear_estado", 16'(estado), 16'd0);
    chk("clear_zera", 16'(zeraTempo), 16'd1);
    chk("clear_display", 16'(display), 16'd0);
    chk("clear_number", 16'(number), 16'd0);
    press(2'b10);
    chk("zerado_ignores_z", 16'(estado), 16'd0);

    // 6. simultaneous presses: Iniciar wins
    press(2'b01);
    chk("restart_estado", 16'(estado), 16'd1);
    press(2'b11);
    chk("both_estado", 16'(estado), 16'd2);
    chk("both_display_live", 16'(display), 16'(cnt_m));

    // lap across counter wrap, then async reset in VOLTA
    press(2'b01);
    hold_m = 1'b1;
    load(14'd777);
    press(2'b10);
    chk("lap2_display", 16'(display), 16'd777);
    hold_m = 1'b0;
    load(14'd9998);
    tick(4);
    chk("wrap_number", 16'(number), 16'd2);
    chk("wrap_estado", 16'(estado), 16'd3);
    chk("wrap_lap_held", 16'(display), 16'd777);
    #2 rst = 1'b1;
    #1;
    chk("arst_estado", 16'(estado), 16'd0);
    chk("arst_zera", 16'(zeraTempo), 16'd1);
    chk("arst_conta", 16'(contaTempo), 16'd0);
    chk("arst_display", 16'(display), 16'd0);
    tick(2);
    rst = 1'b0;
    tick(20);
    chk("post_rst_estado", 16'(estado), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
